// File: rtl/sram_ctrl_pkg.sv
// Shared constants and state type for the single-port SRAM front-end controller.
package sram_ctrl_pkg;

  localparam int ENTRIES = 512;
  localparam int ADDR_W  = 9;
  localparam int LANE_W  = 10;
  localparam int LANES   = 8;
  localparam int DATA_W  = LANES * LANE_W;

  // INIT zero-fills the array after reset; RUN arbitrates live traffic.
  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/sram_resp_fifo.sv
// Two-entry response FIFO that holds read data so the consumer can stall.
module sram_resp_fifo #(
  parameter int WIDTH = sram_ctrl_pkg::DATA_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;

  // Pointer and occupancy tracking; push and pop may coincide.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Data storage.
  // NOTE: the storage array has no reset; occupancy alone decides validity, and this keeps it mappable to plain registers/RAM.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);

endmodule

// File: rtl/sram_1p_ctrl.sv
// Front-end controller for the 512x80 single-port lane-masked SRAM macro:
// zero-fill after reset, read/write arbitration, read-latency tracking and a
// credit-limited response FIFO.
module sram_1p_ctrl #(
  parameter int ENTRIES       = sram_ctrl_pkg::ENTRIES,
  parameter int ADDR_W        = sram_ctrl_pkg::ADDR_W,
  parameter int LANE_W        = sram_ctrl_pkg::LANE_W,
  parameter int LANES         = sram_ctrl_pkg::LANES,
  parameter int DATA_W        = sram_ctrl_pkg::DATA_W,
  parameter int INIT_ON_RESET = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [LANES-1:0]  w_mask,
  input  logic [DATA_W-1:0] w_data,
  input  logic              r_valid,
  output logic              r_ready,
  input  logic [ADDR_W-1:0] r_addr,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [LANES-1:0]  sram_wmask,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata
);

  import sram_ctrl_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              init_done_q;
  logic [1:0]        credit_q, credit_d;
  logic              prio_read_q;
  logic              rd_pending_q;
  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic              run, rd_ok, wr_grant, rd_grant, contend;

  // Traffic is only accepted once the sweep is finished and reset is low.
  assign run        = init_done_q && !reset;
  assign resp_valid = !fifo_empty;
  assign fifo_pop   = resp_valid && resp_ready;
  assign fifo_push  = rd_pending_q;
  assign rd_ok      = (credit_q < 2'd2) || fifo_pop;
  assign w_ready    = run && !(r_valid && rd_ok && prio_read_q);
  assign r_ready    = run && rd_ok && !(w_valid && !prio_read_q);
  assign wr_grant   = w_valid && w_ready;
  assign rd_grant   = r_valid && r_ready;
  assign contend    = run && w_valid && r_valid && rd_ok;
  assign init_done  = init_done_q;

  // Next state: the sweep ends after the last address has been written.
  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    if (state_q == INIT && init_ptr_q == LAST_ADDR) state_d = RUN;
  end

  // State register, sweep pointer and registered init_done flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= (INIT_ON_RESET != 0) ? INIT : RUN;
      init_ptr_q  <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_done_q <= (state_d == RUN);
      if (state_q == INIT) init_ptr_q <= init_ptr_q + ADDR_W'(1);
    end
  end

  // Outstanding-read credit: issued reads not yet consumed by the requester.
  always_comb begin
    credit_d = credit_q;
    case ({rd_grant, fifo_pop})
      2'b10:   credit_d = credit_q + 2'd1;
      2'b01:   credit_d = credit_q - 2'd1;
      default: credit_d = credit_q;
    endcase
  end

  // Credit, fairness toggle and the one-cycle read-latency tracker.
  always_ff @(posedge clock) begin
    if (reset) begin
      credit_q     <= 2'd0;
      prio_read_q  <= 1'b0;
      rd_pending_q <= 1'b0;
    end else begin
      credit_q     <= credit_d;
      rd_pending_q <= rd_grant;
      if (contend) prio_read_q <= ~prio_read_q;
    end
  end

  // Macro drive: sweep write during INIT, otherwise the single granted request.
  always_comb begin
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    if (state_q == INIT && !reset) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = init_ptr_q;
      sram_wmask = '1;
    end else if (wr_grant) begin
      sram_en    = 1'b1;
      sram_wmode = 1'b1;
      sram_addr  = w_addr;
      sram_wmask = w_mask;
      sram_wdata = w_data;
    end else if (rd_grant) begin
      sram_en   = 1'b1;
      sram_addr = r_addr;
    end
  end

  sram_resp_fifo #(.WIDTH(DATA_W)) u_resp_fifo (
    .clock (clock),
    .reset (reset),
    .push  (fifo_push),
    .din   (sram_rdata),
    .pop   (fifo_pop),
    .dout  (resp_data),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // The credit limit keeps read data from ever arriving at a full FIFO without a pop.
  assert property (@(posedge clock) disable iff (reset) !(fifo_full && fifo_push && !fifo_pop));

endmodule

// File: tb/tb_sram_1p_ctrl.sv
// Self-checking bench for sram_1p_ctrl with a behavioural model of the SRAM macro.
module tb_sram_1p_ctrl;
  import sram_ctrl_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              w_valid, w_ready;
  logic [ADDR_W-1:0] w_addr;
  logic [LANES-1:0]  w_mask;
  logic [DATA_W-1:0] w_data;
  logic              r_valid, r_ready;
  logic [ADDR_W-1:0] r_addr;
  logic              resp_valid, resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              init_done;
  logic              sram_en, sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [LANES-1:0]  sram_wmask;
  logic [DATA_W-1:0] sram_wdata, sram_rdata;
  logic              seed_mem;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sram_1p_ctrl dut (
    .clock      (clock),
    .reset      (reset),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_addr     (w_addr),
    .w_mask     (w_mask),
    .w_data     (w_data),
    .r_valid    (r_valid),
    .r_ready    (r_ready),
    .r_addr     (r_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .init_done  (init_done),
    .sram_en    (sram_en),
    .sram_wmode (sram_wmode),
    .sram_addr  (sram_addr),
    .sram_wmask (sram_wmask),
    .sram_wdata (sram_wdata),
    .sram_rdata (sram_rdata)
  );

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                               input logic [DATA_W-1:0] new_w,
                                               input logic [LANES-1:0]  m);
    merge = old_w;
    for (int l = 0; l < LANES; l++)
      if (m[l]) merge[l*LANE_W +: LANE_W] = new_w[l*LANE_W +: LANE_W];
  endfunction

  // Behavioural 512x80 macro: 1-cycle read latency, lane-masked writes.
  // Seeded with non-zero garbage so the zero-fill sweep is observable.
  logic [DATA_W-1:0] sram_mem [ENTRIES];
  always @(posedge clock) begin
    if (seed_mem) begin
      for (int i = 0; i < ENTRIES; i++) sram_mem[i] <= {LANES{LANE_W'(i + 1)}};
    end else if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= merge(sram_mem[sram_addr], sram_wdata, sram_wmask);
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  // Scoreboard: reference contents updated on write handshakes, expected read
  // data queued on read handshakes, compared in order on response handshakes.
  logic [DATA_W-1:0] ref_mem [ENTRIES];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_w;
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < ENTRIES; i++) ref_mem[i] = '0;
    end else begin
      if (resp_valid && resp_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL resp_unexpected: got %h, required no response", resp_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (resp_data !== exp_w) begin
            n_err++;
            $display("FAIL resp_data: got %h, required %h", resp_data, exp_w);
          end
        end
      end
      if (w_valid && w_ready) ref_mem[w_addr] = merge(ref_mem[w_addr], w_data, w_mask);
      if (r_valid && r_ready) exp_q.push_back(ref_mem[r_addr]);
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input logic [LANES-1:0] m);
    int n = 0;
    w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m;
    #1;
    while (!w_ready && n < 50) begin step(); n++; end
    if (!w_ready) begin
      n_cmp++; n_err++;
      $display("FAIL write_timeout: w_ready stayed %b, required 1", w_ready);
    end
    step();
    w_valid = 1'b0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a);
    int n = 0;
    r_valid = 1'b1; r_addr = a;
    #1;
    while (!r_ready && n < 50) begin step(); n++; end
    if (!r_ready) begin
      n_cmp++; n_err++;
      $display("FAIL read_timeout: r_ready stayed %b, required 1", r_ready);
    end
    step();
    r_valid = 1'b0;
  endtask

  task automatic wait_resp();
    int n = 0;
    #1;
    while (!resp_valid && n < 20) begin step(); n++; end
    if (!resp_valid) begin
      n_cmp++; n_err++;
      $display("FAIL resp_timeout: resp_valid stayed %b, required 1", resp_valid);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || resp_valid) && n < 50) begin step(); n++; end
    n_cmp++;
    if (exp_q.size() != 0 || resp_valid) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    logic [15:0] obs [8];
    logic [15:0] req [8];
    string       nm  [8];
    reset = 1'b1; seed_mem = 1'b1;
    w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
    w_addr = '0; w_mask = '0; w_data = '0; r_addr = '0;
    step();
    seed_mem = 1'b0;
    step();
    obs[0] = 16'(w_ready);           req[0] = 16'd0; nm[0] = "rst_w_ready";
    obs[1] = 16'(r_ready);           req[1] = 16'd0; nm[1] = "rst_r_ready";
    obs[2] = 16'(resp_valid);        req[2] = 16'd0; nm[2] = "rst_resp_valid";
    obs[3] = 16'(sram_en);           req[3] = 16'd0; nm[3] = "rst_sram_en";
    obs[4] = 16'(init_done);         req[4] = 16'd0; nm[4] = "rst_init_done";
    obs[5] = 16'(dut.credit_q);      req[5] = 16'd0; nm[5] = "rst_credit";
    obs[6] = 16'(dut.prio_read_q);   req[6] = 16'd0; nm[6] = "rst_prio_read";
    obs[7] = 16'(dut.init_ptr_q);    req[7] = 16'd0; nm[7] = "rst_init_ptr";
    for (int i = 0; i < 8; i++) begin
      n_cmp++;
      if (obs[i] !== req[i]) begin
        n_err++;
        $display("FAIL %s: got %h, required %h", nm[i], obs[i], req[i]);
      end
    end
  endtask

  // Sweep check: intervals 1..512 after release write address k-1 with zero
  // data and full mask; init_done rises in interval 513.
  task automatic check_sweep(input string tag);
    logic [DATA_W+ADDR_W+LANES+4:0] obs, req;
    for (int k = 0; k < ENTRIES; k++) begin
      obs = {sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata, init_done, w_ready, r_ready};
      req = {1'b1, 1'b1, ADDR_W'(k), {LANES{1'b1}}, {DATA_W{1'b0}}, 1'b0, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== req) begin
        n_err++;
        $display("FAIL %s_cycle%0d: got %h, required %h", tag, k + 1, obs, req);
      end
      step();
    end
    n_cmp++;
    if (init_done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_done: init_done got %b, required 1", tag, init_done);
    end
  endtask

  task automatic test_init_sweep();
    reset = 1'b0;
    #1;
    check_sweep("init");
    // Last address after the sweep: zero data, resp_valid two cycles after accept.
    r_valid = 1'b1; r_addr = 9'h1FF;
    #1;
    n_cmp++;
    if (r_ready !== 1'b1) begin
      n_err++;
      $display("FAIL first_read_ready: got %b, required 1", r_ready);
    end
    step();
    r_valid = 1'b0;
    #1;
    n_cmp++;
    if (resp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL latency_n1: resp_valid got %b, required 0", resp_valid);
    end
    step();
    n_cmp++;
    if ({resp_valid, resp_data} !== {1'b1, {DATA_W{1'b0}}}) begin
      n_err++;
      $display("FAIL latency_n2: valid/data got %b/%h, required 1/0", resp_valid, resp_data);
    end
    drain();
  endtask

  task automatic test_masked_write();
    do_write(9'd5, '1, 8'h0F);
    do_read(9'd5);
    wait_resp();
    n_cmp++;
    if (resp_data !== 80'h0000000000FFFFFFFFFF) begin
      n_err++;
      $display("FAIL masked_write: got %h, required %h", resp_data, 80'h0000000000FFFFFFFFFF);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [6:0] rv;
    for (int a = 1; a <= 4; a++) do_write(ADDR_W'(a), {LANES{LANE_W'(a * 37)}}, '1);
    drain();
    resp_ready = 1'b1;
    r_valid = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) r_addr = ADDR_W'(t + 1);
      else       r_valid = 1'b0;
      #1;
      if (t < 4) begin
        n_cmp++;
        if (r_ready !== 1'b1) begin
          n_err++;
          $display("FAIL b2b_ready%0d: got %b, required 1", t, r_ready);
        end
      end
      rv[t] = resp_valid;
      step();
    end
    n_cmp++;
    if (rv !== 7'b0111100) begin
      n_err++;
      $display("FAIL b2b_resp_valid: got %b, required %b", rv, 7'b0111100);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int   acc = 0;
    logic last_ready = 1'b1;
    logic [2:0] rv;
    resp_ready = 1'b0;
    r_valid = 1'b1;
    for (int t = 0; t < 6; t++) begin
      r_addr = ADDR_W'(1 + (t % 4));
      #1;
      if (r_ready) acc++;
      last_ready = r_ready;
      step();
    end
    r_valid = 1'b0;
    n_cmp++;
    if (acc !== 2) begin
      n_err++;
      $display("FAIL bp_accepted: got %0d, required 2", acc);
    end
    n_cmp++;
    if (last_ready !== 1'b0) begin
      n_err++;
      $display("FAIL bp_ready_low: got %b, required 0", last_ready);
    end
    n_cmp++;
    if (resp_valid !== 1'b1) begin
      n_err++;
      $display("FAIL bp_held: resp_valid got %b, required 1", resp_valid);
    end
    resp_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      #1;
      rv[t] = resp_valid;
      step();
    end
    n_cmp++;
    if (rv !== 3'b011) begin
      n_err++;
      $display("FAIL bp_release: resp_valid got %b, required %b", rv, 3'b011);
    end
    do_read(9'd2);
    drain();
  endtask

  task automatic test_contention();
    byte g, e;
    resp_ready = 1'b1;
    w_valid = 1'b1; r_valid = 1'b1; r_addr = 9'd3; w_mask = '1;
    for (int t = 0; t < 6; t++) begin
      w_addr = ADDR_W'(200 + t);
      w_data = {LANES{LANE_W'(500 + t)}};
      #1;
      g = (w_valid && w_ready) ? "W" : ((r_valid && r_ready) ? "R" : "-");
      if (w_valid && w_ready && r_valid && r_ready) g = "2";
      e = (t % 2 == 0) ? "W" : "R";
      n_cmp++;
      if (g !== e || sram_en !== 1'b1 || sram_wmode !== (e == "W")) begin
        n_err++;
        $display("FAIL contention%0d: grant %c en %b wmode %b, required grant %c en 1 wmode %b",
                 t, g, sram_en, sram_wmode, e, (e == "W"));
      end
      step();
    end
    w_valid = 1'b0; r_valid = 1'b0;
    drain();
    do_read(9'd200);
    do_read(9'd201);
    do_read(9'd204);
    drain();
  endtask

  task automatic test_reset_mid_traffic();
    int acc = 0;
    int n = 0;
    resp_ready = 1'b0;
    r_valid = 1'b1; r_addr = 9'd5;
    while (acc < 2 && n < 20) begin
      #1;
      if (r_ready) acc++;
      step();
      n++;
    end
    r_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({resp_valid, dut.credit_q, dut.rd_pending_q, init_done, sram_en, sram_addr} !==
        {1'b0, 2'd0, 1'b0, 1'b0, 1'b1, ADDR_W'(0)}) begin
      n_err++;
      $display("FAIL mid_reset: valid %b credit %0d pending %b done %b en %b addr %h, required 0 0 0 0 1 000",
               resp_valid, dut.credit_q, dut.rd_pending_q, init_done, sram_en, sram_addr);
    end
    resp_ready = 1'b1;
    check_sweep("reinit");
    do_read(9'd5);
    wait_resp();
    n_cmp++;
    if (resp_data !== '0) begin
      n_err++;
      $display("FAIL reinit_zero: got %h, required 0", resp_data);
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_init_sweep();
    test_masked_write();
    test_back_to_back();
    test_back_pressure();
    test_contention();
    test_reset_mid_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
